// File: rtl/rv32_dbus_bridge.sv
// Purpose : RV32 core data-bus bridge; decodes each access to data memory, the
//           machine-timer shadow registers, or unmapped space (bus_err).
// Latency : MEM read MEM_RD_LATENCY+2 cycles, TIMER/UNMAPPED read 2 cycles,
//           writes zero wait states (timer update pulse one cycle later).
// Backpr. : dwaitrequest holds the core while a read is pending; writes never
//           stall, but a write arriving outside IDLE is dropped with bus_err.
// Ports   : clk, reset (async, active high)
//           core  : daddress, dwrite, dwritedata, dbyteenable, dread ->
//                   dreaddata (registered), dwaitrequest (combinational)
//           memory: mem_addr, mem_write, mem_writedata, mem_byteenable,
//                   mem_read -> mem_readdata
//           timer : wr_mtime, wr_mtimecmp, wr_mtime_upper, wr_mtime_val
//           error : bus_err (one-cycle registered pulse)
module rv32_dbus_bridge #(
   parameter int unsigned MEM_ADDR_BITS  = 14,
   parameter int unsigned MEM_RD_LATENCY = 1,
   parameter logic [31:0] TIMER_BASE     = 32'hAFFFFFE0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              daddress,
   input  logic                     dwrite,
   input  logic [31:0]              dwritedata,
   input  logic [3:0]               dbyteenable,
   input  logic                     dread,
   output logic [31:0]              dreaddata,
   output logic                     dwaitrequest,
   output logic [MEM_ADDR_BITS-1:0] mem_addr,
   output logic                     mem_write,
   output logic [31:0]              mem_writedata,
   output logic [3:0]               mem_byteenable,
   output logic                     mem_read,
   input  logic [31:0]              mem_readdata,
   output logic                     wr_mtime,
   output logic                     wr_mtimecmp,
   output logic                     wr_mtime_upper,
   output logic [31:0]              wr_mtime_val,
   output logic                     bus_err
);

   localparam logic [2:0] RD_LAT = 3'(MEM_RD_LATENCY);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [31:0] shadow [4];   // 0 mtime lo, 1 mtime hi, 2 mtimecmp lo, 3 mtimecmp hi
   logic [31:0] merged;
   logic [1:0]  sel;
   logic        is_timer;
   logic        is_mem;
   logic        unused_addr_lsbs;

   // Timer window wins over memory even if the two ever overlap.
   assign is_timer = (daddress[31:4] == TIMER_BASE[31:4]);
   assign is_mem   = !is_timer && (daddress[31:MEM_ADDR_BITS+2] == '0);
   assign sel      = daddress[3:2];

   assign unused_addr_lsbs = ^daddress[1:0];

   assign mem_addr       = daddress[MEM_ADDR_BITS+1:2];
   assign mem_writedata  = dwritedata;
   assign mem_byteenable = dbyteenable;

   // Memory strobes only fire for accesses accepted in IDLE; write beats read.
   assign mem_write = !reset && (state == IDLE) && dwrite && is_mem;
   assign mem_read  = !reset && (state == IDLE) && dread && !dwrite && is_mem;

   // The core is released only in the single RESP cycle of a read.
   assign dwaitrequest = dread && (state != RESP);

   // Byte-merge of write data into the addressed shadow register.
   always_comb begin
      merged = shadow[sel];
      for (int b = 0; b < 4; b++) begin
         if (dbyteenable[b]) merged[8*b +: 8] = dwritedata[8*b +: 8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         dreaddata      <= '0;
         wr_mtime       <= 1'b0;
         wr_mtimecmp    <= 1'b0;
         wr_mtime_upper <= 1'b0;
         wr_mtime_val   <= '0;
         bus_err        <= 1'b0;
         for (int i = 0; i < 4; i++) shadow[i] <= '0;
      end else begin
         wr_mtime    <= 1'b0;
         wr_mtimecmp <= 1'b0;
         bus_err     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (dwrite) begin
                  if (is_timer) begin
                     shadow[sel]    <= merged;
                     wr_mtime       <= ~sel[1];
                     wr_mtimecmp    <= sel[1];
                     wr_mtime_upper <= daddress[2];
                     wr_mtime_val   <= merged;
                  end else if (!is_mem) begin
                     bus_err <= 1'b1;
                  end
               end else if (dread) begin
                  if (is_timer) begin
                     dreaddata <= shadow[sel];
                     state     <= RESP;
                  end else if (is_mem) begin
                     cnt   <= RD_LAT;
                     state <= WAIT;
                  end else begin
                     dreaddata <= '0;
                     bus_err   <= 1'b1;
                     state     <= RESP;
                  end
               end
            end
            WAIT: begin
               if (dwrite) bus_err <= 1'b1;
               cnt <= cnt - 3'd1;
               // Memory data is valid on the cycle the countdown reaches 1.
               if (cnt == 3'd1) begin
                  dreaddata <= mem_readdata;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (dwrite) bus_err <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/rv32_dbus_bridge.md
RV32_DBUS_BRIDGE -- requirements
Module: rv32_dbus_bridge

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 14, giving the word-address width of data memory (64 KB).
REQ-002 SHALL have parameter MEM_RD_LATENCY, default 1, range 1-7, giving the cycles from mem_read to valid mem_readdata.
REQ-003 SHALL have parameter TIMER_BASE, default 32'hAFFFFFE0, giving the 16-byte-aligned timer register window.
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have core-side inputs: daddress 32, dwrite 1, dwritedata 32, dbyteenable 4, dread 1.
REQ-007 SHALL have core-side outputs: dreaddata 32 (registered) and dwaitrequest 1.
REQ-008 SHALL have memory-side ports: mem_addr output MEM_ADDR_BITS, mem_write output 1, mem_writedata output 32, mem_byteenable output 4, mem_read output 1, mem_readdata input 32.
REQ-009 SHALL have timer-side outputs: wr_mtime 1, wr_mtimecmp 1, wr_mtime_upper 1, wr_mtime_val 32, all registered.
REQ-010 SHALL have output bus_err, 1, a one-cycle registered pulse.

Function
REQ-011 SHALL decode addresses as follows:
- TIMER when daddress[31:4]==TIMER_BASE[31:4]; TIMER takes priority over MEM.
- Otherwise MEM when daddress[31:MEM_ADDR_BITS+2]==0.
- Otherwise UNMAPPED.
REQ-012 SHALL drive mem_addr=daddress[MEM_ADDR_BITS+1:2], mem_writedata=dwritedata and mem_byteenable=dbyteenable combinationally.
REQ-013 SHALL implement a read state machine with states IDLE, WAIT and RESP.
REQ-014 SHALL assert dwaitrequest combinationally whenever dread=1 and state!=RESP; dwaitrequest SHALL be 0 in RESP and whenever dread=0.
REQ-015 SHALL handle a MEM read accepted in IDLE (dread=1, dwrite=0) as follows:
- pulse mem_read for exactly that cycle;
- load a counter with MEM_RD_LATENCY and go to WAIT.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and capture mem_readdata into dreaddata on the cycle the counter equals 1, then go to RESP.
- dread is therefore high for MEM_RD_LATENCY+2 cycles per MEM read.
REQ-017 SHALL handle a TIMER read in IDLE as follows:
- load dreaddata from the shadow register selected by daddress[3:2]: 0 mtime lo, 1 mtime hi, 2 mtimecmp lo, 3 mtimecmp hi;
- go directly to RESP (2 cycles total).
REQ-018 SHALL handle an UNMAPPED read in IDLE by loading dreaddata=32'h0, pulsing bus_err and going directly to RESP.
REQ-019 SHALL leave RESP for IDLE unconditionally after one cycle; dreaddata SHALL hold its value until the next capture.
REQ-020 SHALL handle writes accepted only in IDLE with zero wait states:
- MEM: mem_write=dwrite combinationally, same cycle;
- TIMER: update the selected shadow register per byte enable (disabled bytes unchanged);
- TIMER: next cycle pulse wr_mtime (offsets 0/4) or wr_mtimecmp (offsets 8/C) for one cycle;
- with the pulse, wr_mtime_upper=daddress[2] and wr_mtime_val=merged shadow value;
- UNMAPPED: drop the write and pulse bus_err.
REQ-021 SHALL give dwrite priority over dread when both are 1 in IDLE; the read SHALL start the following cycle if dread persists.
REQ-022 SHALL, when dwrite=1 outside IDLE, suppress mem_write, ignore the write and pulse bus_err.
REQ-023 SHALL give byte enables no effect on reads.

Reset
REQ-024 SHALL force the following on reset assertion, regardless of clock:
- state IDLE and counter 0;
- dreaddata, wr_mtime_val and all shadow registers 32'h0;
- wr_mtime, wr_mtimecmp, wr_mtime_upper and bus_err 0.
REQ-025 SHALL abandon any read in progress when reset asserts mid-read, deliver no data and issue no further mem_read after reset release.
REQ-026 SHALL keep mem_read and mem_write at 0 while reset is asserted.

Verification
REQ-027 SHALL test a MEM read: MEM_RD_LATENCY=2, mem_readdata=32'h12345678, dread at daddress 32'h100.
- mem_read pulses cycle 0 with mem_addr=0x40;
- dwaitrequest is 1 in cycles 0-2 and 0 in cycle 3, with dreaddata=32'h12345678.
REQ-028 SHALL test a TIMER write then read.
- Write 32'hCAFEF00D to TIMER_BASE+4, BE=4'hF: next cycle wr_mtime=1, wr_mtime_upper=1, wr_mtime_val=32'hCAFEF00D, for one cycle.
- Read of TIMER_BASE+4 then returns 32'hCAFEF00D in cycle 1.
REQ-029 SHALL test a partial TIMER write: shadow=32'h11223344, write 32'hAABBCCDD to TIMER_BASE+8 with BE=4'b0101.
- Required: wr_mtimecmp pulse with wr_mtime_val=32'h11BB33DD.
REQ-030 SHALL test UNMAPPED accesses at 32'h80000000.
- Read: returns 0 after one wait cycle with a bus_err pulse.
- Write: mem_write stays 0 and bus_err pulses.
REQ-031 SHALL test reset mid-read: assert reset during WAIT.
- All outputs 0 immediately; after release with dread=0, mem_read stays 0 and state is IDLE.
REQ-032 SHALL test a simultaneous dwrite and dread in IDLE on MEM.
- mem_write is 1 and mem_read is 0 that cycle; mem_read pulses the next cycle.
